// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the six-way memory port arbiter.
//   - arb_state_e  : arbiter FSM states (IDLE, ISSUE, WAIT)
//   - NUM_REQ      : number of requesters sharing the port
//   - REQ_*        : requester slot indices
//   - idx_add_mod6 : (a + b) mod 6 for indices already in 0..5
//   - is_onehot0   : true when a 6-bit vector has at most one bit set
package mem_arb_pkg;

  localparam int NUM_REQ = 6;

  localparam logic [2:0] REQ_ICACHE   = 3'd0;
  localparam logic [2:0] REQ_DCACHE   = 3'd1;
  localparam logic [2:0] REQ_WB       = 3'd2;
  localparam logic [2:0] REQ_PTW      = 3'd3;
  localparam logic [2:0] REQ_PREFETCH = 3'd4;
  localparam logic [2:0] REQ_UNCACHED = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Both operands are valid indices (0..5), so one conditional subtract
  // is enough to wrap the sum.
  function automatic logic [2:0] idx_add_mod6(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd6) s = s - 4'd6;
    return s[2:0];
  endfunction

  function automatic logic is_onehot0(input logic [5:0] v);
    return (v & (v - 6'd1)) == 6'd0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter6_rr_pick6.sv
// rr_pick6: combinational rotating-priority pick over six requests.
// The search starts at ptr and wraps 5 -> 0; the first set bit wins.
//   req [5:0] : request vector
//   ptr [2:0] : highest-priority slot (0..5)
//   gnt [5:0] : one-hot winner, zero when req is zero
//   idx [2:0] : winner index (0 when req is zero)
module rr_pick6
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         idx
);

  // cand[k] is the slot examined at search step k.
  logic [2:0] cand [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = idx_add_mod6(ptr, 3'(gi));
    end
  endgenerate

  // Scan from the lowest priority upward so the earliest search step
  // that hits is the last (and therefore final) assignment.
  always_comb begin
    idx = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) idx = cand[k];
    end
    gnt = (req != '0) ? (6'd1 << idx) : 6'd0;
  end

endmodule

// File: rtl/mem_port_arbiter6.sv
// mem_port_arbiter6: round-robin arbiter sharing one downstream memory
// port between six requesters, one transaction outstanding at a time.
//   cpu_clock_i / cpu_reset_i : clock, synchronous active-high reset
//   req_i, addr_i, we_i, wdata_i : per-requester request and payload
//   grant_o        : one-hot owner of the port, zero when idle
//   resp_valid_o   : one-cycle one-hot response strobe to the owner
//   resp_data_o    : registered response data
//   mem_*          : downstream valid/ready request and one-cycle response
//   arb_error_o    : sticky protocol error
// Optional build macro MEM_PORT_ARB_CHECK_EN enables the protocol checker
// behind arb_error_o; without it arb_error_o is tied low.
module mem_port_arbiter6
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic                           cpu_clock_i,
  input  logic                           cpu_reset_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ-1:0]             we_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [NUM_REQ-1:0]             resp_valid_o,
  output logic [DATA_W-1:0]              resp_data_o,
  output logic                           mem_valid_o,
  input  logic                           mem_ready_i,
  output logic [ADDR_W-1:0]              mem_addr_o,
  output logic                           mem_we_o,
  output logic [DATA_W-1:0]              mem_wdata_o,
  input  logic                           mem_resp_valid_i,
  input  logic [DATA_W-1:0]              mem_resp_data_i,
  output logic                           arb_error_o
);

  arb_state_e           state_reg, state_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic [NUM_REQ-1:0]   resp_valid_reg, resp_valid_next;
  logic [DATA_W-1:0]    resp_data_reg, resp_data_next;
  logic                 mem_valid_reg, mem_valid_next;
  logic [ADDR_W-1:0]    addr_reg, addr_next;
  logic                 we_reg, we_next;
  logic [DATA_W-1:0]    wdata_reg, wdata_next;
  logic [2:0]           ptr_reg, ptr_next;
  logic [2:0]           owner_reg, owner_next;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [2:0]           pick_idx;

  rr_pick6 u_pick (
    .req (req_i),
    .ptr (ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    resp_valid_next = '0;
    resp_data_next  = resp_data_reg;
    mem_valid_next  = mem_valid_reg;
    addr_next       = addr_reg;
    we_next         = we_reg;
    wdata_next      = wdata_reg;
    ptr_next        = ptr_reg;
    owner_next      = owner_reg;
    case (state_reg)
      IDLE: begin
        // While the response strobe is up we skip arbitration for one
        // cycle, giving the owner time to drop its request.
        if (resp_valid_reg == '0 && req_i != '0) begin
          grant_next     = pick_gnt;
          owner_next     = pick_idx;
          addr_next      = addr_i[pick_idx];
          we_next        = we_i[pick_idx];
          wdata_next     = wdata_i[pick_idx];
          mem_valid_next = 1'b1;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        // A response coinciding with acceptance is not taken here.
        if (mem_ready_i) begin
          mem_valid_next = 1'b0;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid_i) begin
          resp_data_next  = mem_resp_data_i;
          resp_valid_next = grant_reg;
          grant_next      = '0;
          ptr_next        = idx_add_mod6(owner_reg, 3'd1);
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      resp_valid_reg <= '0;
      resp_data_reg  <= '0;
      mem_valid_reg  <= 1'b0;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      ptr_reg        <= REQ_ICACHE;
      owner_reg      <= REQ_ICACHE;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      resp_valid_reg <= resp_valid_next;
      resp_data_reg  <= resp_data_next;
      mem_valid_reg  <= mem_valid_next;
      addr_reg       <= addr_next;
      we_reg         <= we_next;
      wdata_reg      <= wdata_next;
      ptr_reg        <= ptr_next;
      owner_reg      <= owner_next;
    end
  end

  assign grant_o      = grant_reg;
  assign resp_valid_o = resp_valid_reg;
  assign resp_data_o  = resp_data_reg;
  assign mem_valid_o  = mem_valid_reg;
  assign mem_addr_o   = addr_reg;
  assign mem_we_o     = we_reg;
  assign mem_wdata_o  = wdata_reg;

`ifdef MEM_PORT_ARB_CHECK_EN
  logic err_reg, err_next;

  always_comb begin
    err_next = err_reg;
    if (!is_onehot0(grant_reg))                   err_next = 1'b1;
    if (!is_onehot0(resp_valid_reg))              err_next = 1'b1;
    if (mem_resp_valid_i && (state_reg != WAIT))  err_next = 1'b1;
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) err_reg <= 1'b0;
    else             err_reg <= err_next;
  end

  assign arb_error_o = err_reg;
`else
  assign arb_error_o = 1'b0;
`endif

endmodule
